// File: rtl/mm_pkg.sv
// Shared constants and types for the 3072-bit modular multiplier datapath.
package mm_pkg;
    localparam int SIZE   = 3072;
    localparam int CHUNK  = 128;
    localparam int NCHUNK = SIZE / CHUNK;
    localparam int IDX_W  = $clog2(NCHUNK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        HOLD = 2'd2
    } fr_state_t;
endpackage

// File: rtl/sub_chunk_128.sv
// One 128-bit slice of the chunked subtractor: {borrow_out, diff} = a - b - borrow_in.
module sub_chunk_128 (
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic         borrow_in,
    output logic [127:0] diff,
    output logic         borrow_out
);
    logic [128:0] wide_s;

    // 129-bit subtract so the wrap-around bit is the outgoing borrow
    always_comb begin
        wide_s     = {1'b0, a} - {1'b0, b} - {128'd0, borrow_in};
        diff       = wide_s[127:0];
        borrow_out = wide_s[128];
    end
endmodule

// File: rtl/final_reduce_3072.sv
// Final reduction stage: feedback routing for non-final iterations, and a chunked
// conditional subtraction of m for the last iteration presented on a valid/ready port.
module final_reduce_3072
    import mm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_last,
    input  logic [SIZE-1:0] in_a,
    input  logic [SIZE-1:0] m,
    output logic            fb_valid,
    output logic [SIZE-1:0] fb_a,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_r,
    output logic            busy,
    output logic            overrun
);
    fr_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic [SIZE-1:0]  reg_a_q, reg_a_d;
    logic [SIZE-1:0]  diff_q, diff_d;
    logic [SIZE-1:0]  out_r_q, out_r_d;
    logic [SIZE-1:0]  fb_a_q, fb_a_d;
    logic             fb_valid_q, fb_valid_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;

    logic [CHUNK-1:0] slice_a_s, slice_m_s, slice_d_s;
    logic             slice_bout_s;
    logic             last_in_s, handshake_s, accept_s;

    // select the active slice of both operands
    always_comb begin
        slice_a_s = reg_a_q[idx_q*CHUNK +: CHUNK];
        slice_m_s = m[idx_q*CHUNK +: CHUNK];
    end

    sub_chunk_128 u_sub (
        .a          (slice_a_s),
        .b          (slice_m_s),
        .borrow_in  (borrow_q),
        .diff       (slice_d_s),
        .borrow_out (slice_bout_s)
    );

    // next-state, datapath and output-register computation
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        borrow_d   = borrow_q;
        reg_a_d    = reg_a_q;
        diff_d     = diff_q;
        out_r_d    = out_r_q;
        fb_a_d     = fb_a_q;
        fb_valid_d = 1'b0;
        overrun_d  = overrun_q;

        last_in_s   = in_valid && in_last;
        handshake_s = (state_q == HOLD) && out_valid_q && out_ready;
        accept_s    = last_in_s && ((state_q == IDLE) || handshake_s);

        if (in_valid && !in_last) begin
            fb_a_d     = in_a;
            fb_valid_d = 1'b1;
        end else begin
            fb_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SUB: begin
                diff_d[idx_q*CHUNK +: CHUNK] = slice_d_s;
                borrow_d = slice_bout_s;
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    // final borrow set means reg_a < m, so the subtraction is discarded
                    out_r_d = slice_bout_s ? reg_a_q : {slice_d_s, diff_q[SIZE-CHUNK-1:0]};
                    idx_d   = '0;
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept_s) begin
            reg_a_d  = in_a;
            idx_d    = '0;
            borrow_d = 1'b0;
            state_d  = SUB;
        end else if (last_in_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            reg_a_q     <= '0;
            diff_q      <= '0;
            out_r_q     <= '0;
            fb_a_q      <= '0;
            fb_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            reg_a_q     <= reg_a_d;
            diff_q      <= diff_d;
            out_r_q     <= out_r_d;
            fb_a_q      <= fb_a_d;
            fb_valid_q  <= fb_valid_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign fb_valid  = fb_valid_q;
    assign fb_a      = fb_a_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_final_reduce_3072.sv
// Self-checking bench for final_reduce_3072: directed vectors, multi-cycle corner
// sequences, and random operands checked against a plain-arithmetic reference.
module tb_final_reduce_3072;
    import mm_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_last, out_ready;
    logic [SIZE-1:0] in_a, m;
    logic            fb_valid, out_valid, busy, overrun;
    logic [SIZE-1:0] fb_a, out_r;

    int total = 0;
    int bad   = 0;

    final_reduce_3072 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_a(in_a),
        .m(m), .fb_valid(fb_valid), .fb_a(fb_a), .out_valid(out_valid),
        .out_ready(out_ready), .out_r(out_r), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] m;
        logic [SIZE-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk_w(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got[127:0]=%h want[127:0]=%h", name, act[127:0], exp[127:0]);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    // reference: conditional subtraction of m from a value known to be < 2m
    function automatic logic [SIZE-1:0] ref_reduce(input logic [SIZE-1:0] a, input logic [SIZE-1:0] mm);
        return (a >= mm) ? a - mm : a;
    endfunction

    function automatic logic [SIZE-1:0] rand_wide();
        logic [SIZE-1:0] v;
        for (int i = 0; i < SIZE / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic start_last(input logic [SIZE-1:0] a);
        in_a     = a;
        in_valid = 1'b1;
        in_last  = 1'b1;
    endtask

    // clears the pulse and counts cycles until out_valid (latency 25 expected)
    task automatic wait_out(output int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_vec(input string name, input logic [SIZE-1:0] a, input logic [SIZE-1:0] mm,
                           input logic [SIZE-1:0] exp);
        int n;
        m = mm;
        start_last(a);
        wait_out(n);
        chk_i({name, "_lat"}, n, 25);
        chk_i({name, "_ov"}, int'(out_valid), 1);
        chk_w({name, "_r"}, out_r, exp);
        @(negedge clk);
    endtask

    initial begin
        logic [SIZE-1:0] t, a, mm;
        int n;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_a = '0; m = '0;
        repeat (3) @(negedge clk);
        chk_i("rst_fb_valid", int'(fb_valid), 0);
        chk_i("rst_out_valid", int'(out_valid), 0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_overrun", int'(overrun), 0);
        chk_w("rst_out_r", out_r, '0);
        chk_w("rst_fb_a", fb_a, '0);
        rst = 1'b0;
        @(negedge clk);

        // feedback path
        in_a = SIZE'(32'h1234); in_valid = 1'b1; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk_i("fb_valid_t1", int'(fb_valid), 1);
        chk_w("fb_a_t1", fb_a, SIZE'(32'h1234));
        chk_i("fb_no_out", int'(out_valid), 0);
        chk_i("fb_no_busy", int'(busy), 0);
        @(negedge clk);
        chk_i("fb_valid_t2", int'(fb_valid), 0);

        // directed table
        mm = SIZE'(32'hFFFF_0001);
        vecs[0] = '{"sub_taken", mm + SIZE'(5), mm, SIZE'(5)};
        vecs[1] = '{"eq_m", mm, mm, '0};
        vecs[2] = '{"not_taken", mm - SIZE'(1), mm, mm - SIZE'(1)};
        t = '0; t[128] = 1'b1;
        vecs[3] = '{"xchunk_128", t, SIZE'(1), {{(SIZE-128){1'b0}}, {128{1'b1}}}};
        t = '0; t[SIZE-1] = 1'b1;
        vecs[4] = '{"xchunk_top", t, {1'b0, {(SIZE-1){1'b1}}}, SIZE'(1)};
        for (int i = 0; i < 5; i++) run_vec(vecs[i].name, vecs[i].a, vecs[i].m, vecs[i].exp);

        // backpressure then back-to-back accept in the handshake cycle
        out_ready = 1'b0;
        m = mm;
        start_last(mm + SIZE'(7));
        wait_out(n);
        chk_i("bp_lat", n, 25);
        for (int i = 0; i < 10; i++) begin
            chk_w("bp_hold_r", out_r, SIZE'(7));
            chk_i("bp_hold_v", int'(out_valid), 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        start_last(mm);
        wait_out(n);
        chk_i("b2b_lat", n, 25);
        chk_w("b2b_r", out_r, '0);
        chk_i("b2b_no_overrun", int'(overrun), 0);
        @(negedge clk);

        // overrun during SUB leaves first result intact
        start_last(mm + SIZE'(3));
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (4) @(negedge clk);
        start_last(mm - SIZE'(9));
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk_i("overrun_set", int'(overrun), 1);
        n = 6;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk_i("ovr_lat", n, 25);
        chk_w("ovr_first_r", out_r, SIZE'(3));
        @(negedge clk);
        chk_i("ovr_idle", int'(busy), 0);

        // reset at SUB cycle 12
        start_last(mm + SIZE'(11));
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (11) @(negedge clk);
        chk_i("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_i("mid_rst_busy", int'(busy), 0);
        chk_i("mid_rst_overrun", int'(overrun), 0);
        chk_i("mid_rst_out_valid", int'(out_valid), 0);
        chk_w("mid_rst_out_r", out_r, '0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk_i("no_out_after_rst", n, 0);
        run_vec("post_rst", mm + SIZE'(2), mm, SIZE'(2));

        // random operands against the reference
        for (int i = 0; i < 20; i++) begin
            mm = rand_wide();
            mm[SIZE-1] = 1'b0;
            mm[0] = 1'b1;
            t = rand_wide();
            case ($urandom_range(2, 0))
                0: a = t % mm;
                1: a = mm + (t % mm);
                default: a = mm;
            endcase
            run_vec("rand", a, mm, ref_reduce(a, mm));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/final_reduce_3072.md
# final_reduce_3072

Final-reduction and result-routing stage directly downstream of the per-digit reduction phase of the 3072-bit modular multiplier. It captures the reduced value (`in_a < 2m`) on the phase's one-cycle done pulse. Non-final iterations are registered onto the feedback path. The final iteration goes through a conditional subtraction of `m`, computed over 24 cycles in 128-bit chunks to match the 128-bit carry chains already used in the datapath, and is then presented on a valid/ready result port.

## Interface
- `Size`, 3072, operand width
- `Chunk`, 128, subtraction slice width
- `NChunk`, `Size/Chunk` = 24, slice count; `Size` must be a multiple of `Chunk`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  one-cycle pulse: `in_a` valid (reduction phase done)
- `in_last`  in  1  qualifies `in_valid`: 1 = final digit iteration
- `in_a`  in  Size  reduced value from the phase, `< 2m`
- `m`  in  Size  modulus; stable from accept of a last result until its output handshake
- `fb_valid`  out  1  one-cycle pulse: `fb_a` updated
- `fb_a`  out  Size  feedback operand for the next iteration
- `out_valid`  out  1  final result valid
- `out_ready`  in  1  consumer accepts result
- `out_r`  out  Size  final result, `< m`
- `busy`  out  1  state is SUB or HOLD
- `overrun`  out  1  sticky: a last result was dropped

## Operation
- States:
  - IDLE: ready for a last result.
  - SUB: chunked subtract in progress.
  - HOLD: result presented.
- Feedback path, independent of state:
  - `in_valid & !in_last` in cycle T: `fb_a <= in_a` at the end of T.
  - `fb_valid` is high in cycle T+1 only.
- Last accept occurs when `in_valid & in_last` and either:
  - state is IDLE, or
  - state is HOLD with `out_valid & out_ready` in the same cycle (back-to-back).
- On accept:
  - `reg_a <= in_a`, `idx <= 0`, `borrow <= 0`, state goes to SUB.
  - `fb_valid` is not asserted for a last result.
- SUB, each cycle with slice k = idx:
  - `{b', d} = reg_a[k] - m[k] - borrow`, computed 129 bits wide.
  - `diff[k] <= d`, `borrow <= b'`, `idx <= idx+1`.
- Exit SUB on the cycle with `idx == NChunk-1`:
  - `out_r <= b' ? reg_a : {d, diff[NChunk-2:0]}`.
  - State goes to HOLD.
- HOLD:
  - `out_valid = 1`, and `out_r` is held stable until `out_ready`.
  - On handshake, go to IDLE, or to SUB if a back-to-back accept occurs.
- `in_valid & in_last` while in SUB, or in HOLD without handshake:
  - The input is dropped and `overrun <= 1`.
  - In-flight data is untouched.
- Reset values: `rst` forces state IDLE. All outputs go to 0: `fb_valid`, `fb_a`, `out_valid`, `out_r`, `busy`, `overrun`. `idx` and `borrow` also clear.
- Reset mid-SUB or mid-HOLD aborts the operation; no `out_valid` is produced for it.

## Timing
- Feedback latency: 1 cycle, `in_valid` at T gives `fb_valid` at T+1.
- Final latency: accept at T; SUB in cycles T+1..T+24; `out_valid` first high at T+25.
- Throughput: one last result per 25 cycles with `out_ready` held at 1. With back-to-back accept, the next SUB starts the cycle after the handshake.
- `busy` is high from T+1 through the handshake cycle.
- No combinational path from any input to any output.

## Structure
- Shared package `mm_pkg`:
  - `SIZE`, `CHUNK`, `NCHUNK` localparams.
  - `fr_state_t` enum {IDLE, SUB, HOLD}.
- One sub-module: `sub_chunk_128`, combinational 128-bit subtract with borrow-in/borrow-out. It is instantiated once and muxed by `idx`.

## Test plan
- Feedback: pulse `in_valid=1, in_last=0, in_a=0x1234` → `fb_valid` exactly one cycle later with `fb_a=0x1234`; `out_valid` stays 0.
- Subtract taken: `m=0xFFFF_0001`, last `in_a=m+5` → at T+25 `out_valid=1` and `out_r=5`. Also `in_a=m` → `out_r=0`.
- Subtract not taken: last `in_a=m-1` → `out_r=m-1`.
- Cross-chunk borrow: `m=1`, `in_a=2^128` → `out_r=2^128-1`. Also `in_a=2^3071`, `m=2^3071-1` → `out_r=1`.
- Backpressure and overrun:
  - `out_ready=0` for 10 cycles: `out_r` is stable.
  - A second last pulse during SUB sets `overrun=1`; the first result is unchanged.
  - A last pulse in the handshake cycle starts the next SUB with no `overrun`.
- Reset: assert `rst` at SUB cycle 12 → next cycle all outputs are 0 and state is IDLE; no `out_valid` follows; a fresh last accept completes normally.
